fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage sitting directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word fetches to instruction memory over a request/grant bus with in-order, variable-latency responses.
- Buffers returned instructions so none are lost while the pipeline stalls.
- Presents {pc, instr} to IF/ID with a valid/ready handshake.
- Handles branch redirects by discarding all in-flight and buffered fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset.
ADDR_W, 32, PC/address width.
INSTR_W, 32, instruction width.
MAX_OUTST, 2, max fetches in flight plus buffered (FIFO depth); power of 2, >=1.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-low reset.
start_i  in  1  run enable; fetching occurs only while high.
imem_req_o  out  1  fetch request.
imem_addr_o  out  ADDR_W  fetch address (current PC).
imem_gnt_i  in  1  request accepted this cycle when imem_req_o & imem_gnt_i.
imem_rvalid_i  in  1  response valid.
imem_rdata_i  in  INSTR_W  response instruction.
redirect_i  in  1  flush and redirect (taken branch/jump from later stage).
redirect_pc_i  in  ADDR_W  new PC on redirect.
valid_o  out  1  instr_o/pc_o valid toward IF/ID.
ready_i  in  1  IF/ID can accept (low = stall / IFIDwrite deasserted).
instr_o  out  INSTR_W  fetched instruction (FIFO head).
pc_o  out  ADDR_W  address of instr_o.
perf_fetch_o  out  32  delivered-instruction count (optional feature).
perf_stall_o  out  32  stall-cycle count (optional feature).

Behaviour:
- Reset (rst_i low, async):
  - pc=RESET_PC; FIFO empty; outst=0; drop=0; state=IDLE.
  - imem_req_o=0, valid_o=0, instr_o=0, pc_o=0, perf counters=0.
- FSM IDLE/RUN:
  - IDLE->RUN when start_i=1.
  - RUN->IDLE when start_i=0.
  - In IDLE no new requests issue, but in-flight responses are still accepted into the FIFO and delivered.
- Request:
  - imem_req_o = RUN & ~redirect_i & (outst + fifo_cnt < MAX_OUTST).
  - imem_addr_o = pc.
  - On grant: pc <= pc+4, outst++, and the granted address is pushed into an in-order address queue (depth MAX_OUTST) for pc_o pairing.
- Response:
  - Each imem_rvalid_i decrements outst.
  - If drop>0: decrement drop and discard the data.
  - Otherwise push {addr, rdata} into the FIFO.
  - Slot accounting guarantees the FIFO never overflows. A response with outst=0 is a protocol error and is ignored.
- Output:
  - valid_o = fifo not empty; instr_o/pc_o are the FIFO head (registered storage, no combinational path from imem_rdata_i).
  - Pop on valid_o & ready_i. Latency grant->valid_o is at least response latency + 1 cycle.
  - instr_o/pc_o hold stable while valid_o & ~ready_i.
- Redirect (priority over everything in that cycle):
  - pc <= redirect_pc_i; FIFO and address queue cleared; valid_o=0 next cycle.
  - drop <= outst - (imem_rvalid_i ? 1 : 0); outst tracks in-flight count unchanged otherwise.
  - No request issues in the redirect cycle.
  - A pop occurring in the same cycle is counted, but the popped data is also flushed downstream by IF/ID flush.
- Simultaneous push and pop on the FIFO: both occur; fifo_cnt is unchanged.
- Wrap-around: pc+4 wraps modulo 2^ADDR_W; FIFO pointers wrap modulo MAX_OUTST.
- start_i dropping mid-operation: outstanding fetches still complete and deliver. No partial state is lost.
- Reset mid-operation clears everything. Any late imem responses after reset have outst=0 and are ignored.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - perf_fetch_o increments on each pop (valid_o & ready_i).
  - perf_stall_o increments each cycle valid_o & ~ready_i.
  - Both are saturating at 32'hFFFF_FFFF and cleared by reset.
- FETCH_PERF_CNT_EN undefined: counters are not built; perf_fetch_o and perf_stall_o are tied to 0.

Test Plan:
- Reset release, start_i=1, gnt always 1, rvalid 1 cycle after grant, ready_i=1 -> pc_o sequence 0x0,0x4,0x8,0xC on consecutive valid_o cycles; instr_o matches memory image.
- ready_i=0 for 5 cycles mid-stream -> imem_req_o drops once outst+fifo_cnt=2; valid_o holds pc_o=0x8 stable; resumes with 0x8,0xC, no loss or duplicate.
- redirect_i with redirect_pc_i=0x100 while 2 fetches in flight -> both responses discarded; next valid_o has pc_o=0x100; first request after redirect has addr 0x100.
- redirect_i in the same cycle as imem_rvalid_i and grant-ready conditions -> no request that cycle; the returning response is dropped (drop=1 for the one remaining in flight); next delivered pc_o=redirect target.
- rst_i asserted low asynchronously mid-burst (between clock edges) -> outputs zero immediately; after release, first imem_addr_o=RESET_PC.
- With FETCH_PERF_CNT_EN: 10 delivered instructions and 3 stall cycles -> perf_fetch_o=10, perf_stall_o=3. Without the macro -> both read 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit boundary: imem request/response bus, IF/ID handshake, redirect and perf taps.
// master = fetch unit side, slave = environment (memory, IF/ID, branch unit).
interface fetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               start_i;
  logic               imem_req_o;
  logic [ADDR_W-1:0]  imem_addr_o;
  logic               imem_gnt_i;
  logic               imem_rvalid_i;
  logic [INSTR_W-1:0] imem_rdata_i;
  logic               redirect_i;
  logic [ADDR_W-1:0]  redirect_pc_i;
  logic               valid_o;
  logic               ready_i;
  logic [INSTR_W-1:0] instr_o;
  logic [ADDR_W-1:0]  pc_o;
  logic [31:0]        perf_fetch_o;
  logic [31:0]        perf_stall_o;

  modport master (
    input  start_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
           redirect_i, redirect_pc_i, ready_i,
    output imem_req_o, imem_addr_o, valid_o, instr_o, pc_o,
           perf_fetch_o, perf_stall_o
  );

  modport slave (
    output start_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
           redirect_i, redirect_pc_i, ready_i,
    input  imem_req_o, imem_addr_o, valid_o, instr_o, pc_o,
           perf_fetch_o, perf_stall_o
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC owner, in-order imem requester, instruction FIFO toward IF/ID.
// Optional perf counters built only when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                INSTR_W   = 32,
  parameter int                MAX_OUTST = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_unit_if.master  bus
);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] instr;
  } fetch_ent_t;

  state_t                            state;
  logic [ADDR_W-1:0]                 pc;
  logic [CW-1:0]                     outst, drop, fcnt;
  logic [PW-1:0]                     wptr, rptr, aq_wptr, aq_rptr;
  fetch_ent_t [MAX_OUTST-1:0]        fifo;
  logic [MAX_OUTST-1:0][ADDR_W-1:0]  aq;

  logic [CW:0] slots_used;
  logic        req, grant, rsp, keep, valid, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

  // In-flight plus buffered never exceeds the FIFO depth, so a response always has a slot.
  assign slots_used = {1'b0, outst} + {1'b0, fcnt};
  assign req   = (state == RUN) & ~bus.redirect_i & (slots_used < (CW+1)'(MAX_OUTST));
  assign grant = req & bus.imem_gnt_i;
  assign rsp   = bus.imem_rvalid_i & (outst != '0);
  assign keep  = rsp & (drop == '0);
  assign valid = (fcnt != '0);
  assign pop   = valid & bus.ready_i;

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = pc;
  assign bus.valid_o     = valid;
  assign bus.instr_o     = fifo[rptr].instr;
  assign bus.pc_o        = fifo[rptr].addr;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start_i)  state <= RUN;
        RUN:     if (!bus.start_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc      <= RESET_PC;
      outst   <= '0;
      drop    <= '0;
      fcnt    <= '0;
      wptr    <= '0;
      rptr    <= '0;
      aq_wptr <= '0;
      aq_rptr <= '0;
      fifo    <= '0;
      aq      <= '0;
    end else begin
      outst <= outst + CW'(grant) - CW'(rsp);
      if (bus.redirect_i) begin
        // Everything still in flight belongs to the squashed path.
        pc      <= bus.redirect_pc_i;
        drop    <= outst - CW'(rsp);
        fcnt    <= '0;
        wptr    <= '0;
        rptr    <= '0;
        aq_wptr <= '0;
        aq_rptr <= '0;
      end else begin
        if (grant) begin
          pc          <= pc + ADDR_W'(4);
          aq[aq_wptr] <= pc;
          aq_wptr     <= ptr_inc(aq_wptr);
        end
        if (rsp && drop != '0) drop <= drop - CW'(1);
        if (keep) begin
          fifo[wptr] <= {aq[aq_rptr], bus.imem_rdata_i};
          wptr       <= ptr_inc(wptr);
          aq_rptr    <= ptr_inc(aq_rptr);
        end
        if (pop) rptr <= ptr_inc(rptr);
        fcnt <= fcnt + CW'(keep) - CW'(pop);
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_stall;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_fetch <= '0;
      perf_stall <= '0;
    end else begin
      if (pop && perf_fetch != '1)                      perf_fetch <= perf_fetch + 32'd1;
      if (valid && !bus.ready_i && perf_stall != '1)    perf_stall <= perf_stall + 32'd1;
    end
  end

  assign bus.perf_fetch_o = perf_fetch;
  assign bus.perf_stall_o = perf_stall;
`else
  assign bus.perf_fetch_o = '0;
  assign bus.perf_stall_o = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle table for the basic/stall stream, directed redirect and
// reset sequences, then randomized traffic against an in-order PC-stream reference model.
module tb_fetch_unit;
  localparam int          ADDR_W    = 32;
  localparam int          INSTR_W   = 32;
  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .INSTR_W(INSTR_W), .MAX_OUTST(MAX_OUTST))
    dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));

  typedef struct { logic [31:0] addr; int due; } rsp_t;
  typedef struct {
    logic ready; logic req; logic [31:0] addr; logic valid; logic [31:0] pc;
  } vec_t;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  rsp_t rq[$];
  int lat_min = 1, lat_max = 1, gnt_pct = 100, rv_pct = 100;
  logic cur_ready = 1'b1, cur_redirect = 1'b0, cur_start = 1'b0, stray = 1'b0;
  logic [31:0] cur_tgt = '0;
  logic [31:0] exp_pc, exp_req;
  int n_pop, n_stall;
  logic p_valid, p_ready, p_redir, p_start;
  logic [31:0] p_pc, p_instr;
  logic s_req, s_valid, s_gnt;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One cycle: drive memory/control inputs after negedge, sample settled outputs, update model.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (stray) begin
      bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = 32'hDEAD_BEEF; stray = 1'b0;
    end else if (rq.size() != 0 && rq[0].due <= cyc && $urandom_range(99) < rv_pct) begin
      bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = mem_word(rq[0].addr);
      void'(rq.pop_front());
    end else begin
      bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = $urandom;
    end
    s_gnt             = ($urandom_range(99) < gnt_pct);
    bus.imem_gnt_i    = s_gnt;
    bus.start_i       = cur_start;
    bus.ready_i       = cur_ready;
    bus.redirect_i    = cur_redirect;
    bus.redirect_pc_i = cur_tgt;
    #1;
    s_req = bus.imem_req_o; s_addr = bus.imem_addr_o;
    s_valid = bus.valid_o; s_pc = bus.pc_o; s_instr = bus.instr_o;

    if (cur_redirect) chk("req_in_redirect", s_req, 0);
    if (!p_start)     chk("req_while_idle", s_req, 0);
    if (p_redir) chk("valid_after_redirect", s_valid, 0);
    else if (p_valid && !p_ready) begin
      chk("stall_hold_valid", s_valid, 1);
      chk("stall_hold_pc", s_pc, p_pc);
      chk("stall_hold_instr", s_instr, p_instr);
    end
    if (s_req && s_gnt) begin
      chk("req_addr", s_addr, exp_req);
      rq.push_back('{s_addr, cyc + int'($urandom_range(lat_max, lat_min))});
      exp_req += 32'd4;
    end
    if (s_valid && cur_ready) begin
      chk("pop_pc", s_pc, exp_pc);
      chk("pop_instr", s_instr, mem_word(exp_pc));
      exp_pc += 32'd4;
      n_pop++;
    end
    if (s_valid && !cur_ready) n_stall++;
    if (cur_redirect) begin
      exp_pc = cur_tgt; exp_req = cur_tgt;
    end
    p_valid = s_valid; p_ready = cur_ready; p_redir = cur_redirect;
    p_start = cur_start; p_pc = s_pc; p_instr = s_instr;
  endtask

  task automatic check_perf();
    @(posedge clk);
    #1;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", bus.perf_fetch_o, 32'(n_pop));
    chk("perf_stall", bus.perf_stall_o, 32'(n_stall));
`else
    chk("perf_fetch_off", bus.perf_fetch_o, 0);
    chk("perf_stall_off", bus.perf_stall_o, 0);
`endif
  endtask

  // Asserts reset between clock edges, checks outputs clear at once, releases away from an edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", bus.imem_req_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_pc", bus.pc_o, 0);
    chk("rst_instr", bus.instr_o, 0);
    chk("rst_perf_fetch", bus.perf_fetch_o, 0);
    chk("rst_perf_stall", bus.perf_stall_o, 0);
    rq.delete();
    exp_pc = RESET_PC; exp_req = RESET_PC; n_pop = 0; n_stall = 0;
    p_valid = 0; p_ready = 0; p_redir = 0; p_start = 0; p_pc = '0; p_instr = '0;
    cur_start = 0; cur_ready = 1; cur_redirect = 0; stray = 0;
    bus.start_i = 0; bus.imem_gnt_i = 0; bus.imem_rvalid_i = 0; bus.redirect_i = 0;
    @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic run_until_pc(input logic [31:0] stop_pc, input int budget, input string name);
    int k = 0;
    while (exp_pc != stop_pc && k < budget) begin step(); k++; end
    chk(name, exp_pc, stop_pc);
  endtask

  initial begin
    vec_t tbl[15];
    int k;
    bus.start_i = 0; bus.imem_gnt_i = 0; bus.imem_rvalid_i = 0; bus.imem_rdata_i = '0;
    bus.redirect_i = 0; bus.redirect_pc_i = '0; bus.ready_i = 1;

    // Cycle-exact stream: gnt always, latency 1, IF/ID stall over cycles 6..10.
    tbl = '{
      '{1'b1, 1'b0, 32'h00, 1'b0, 32'h00}, '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00},
      '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00}, '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00},
      '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04}, '{1'b1, 1'b1, 32'h0C, 1'b0, 32'h00},
      '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08}, '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08},
      '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08}, '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08},
      '{1'b0, 1'b0, 32'h00, 1'b1, 32'h08}, '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08},
      '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C}, '{1'b1, 1'b1, 32'h14, 1'b0, 32'h00},
      '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10}
    };

    do_reset();
    lat_min = 1; lat_max = 1; gnt_pct = 100; rv_pct = 100; cur_start = 1;
    for (int i = 0; i < 15; i++) begin
      cur_ready = tbl[i].ready;
      step();
      chk($sformatf("tbl%0d_req", i), s_req, tbl[i].req);
      if (tbl[i].req) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].valid);
      if (tbl[i].valid) chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
    end
    check_perf();

    // Redirect to 0x100 with two fetches in flight.
    lat_min = 3; lat_max = 3; cur_ready = 1;
    k = 0;
    while (rq.size() < 2 && k < 20) begin step(); k++; end
    chk("two_in_flight", 32'(rq.size()), 2);
    cur_tgt = 32'h100; cur_redirect = 1; step(); cur_redirect = 0;
    run_until_pc(32'h104, 40, "redirect_0x100_delivered");

    // Redirect coinciding with a returning response.
    lat_min = 1; lat_max = 1;
    k = 0;
    while (!(rq.size() != 0 && rq[0].due <= cyc + 1) && k < 20) begin step(); k++; end
    cur_tgt = 32'h200; cur_redirect = 1; step(); cur_redirect = 0;
    chk("redirect_rvalid_same_cycle", bus.imem_rvalid_i, 1);
    run_until_pc(32'h204, 40, "redirect_0x200_delivered");

    // PC wrap-around.
    cur_tgt = 32'hFFFF_FFF8; cur_redirect = 1; step(); cur_redirect = 0;
    run_until_pc(32'h0000_0004, 40, "pc_wrap");
    check_perf();

    // Async reset mid-burst, then a stray response with nothing outstanding.
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 5; i++) step();
    do_reset();
    stray = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stray_rsp_ignored", s_valid, 0);
    end
    cur_start = 1;
    k = 0;
    while (exp_req == RESET_PC && k < 10) begin step(); k++; end
    chk("first_req_after_reset", exp_req, RESET_PC + 32'd4);

    // Randomized traffic.
    lat_min = 1; lat_max = 4; gnt_pct = 70; rv_pct = 75;
    for (int i = 0; i < 3000; i++) begin
      cur_ready = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 2) cur_start = ~cur_start;
      cur_redirect = ($urandom_range(99) < 3);
      cur_tgt = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      step();
    end
    cur_redirect = 0; cur_start = 1; cur_ready = 1; gnt_pct = 100; rv_pct = 100;
    cur_tgt = 32'h4000; cur_redirect = 1; step(); cur_redirect = 0;
    run_until_pc(32'h4010, 60, "random_drain");
    check_perf();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
